// File: rtl/lsu_align_unit_if.sv
// Core-side request/response and memory-side transaction signals of lsu_align_unit.
// master = environment (core + memory), slave = the alignment unit.
interface lsu_align_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: B/H/W core accesses to word-aligned memory transactions.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions.
module lsu_align_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  lsu_align_unit_if.slave lsu
);
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, next_state;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic                  crossing;
`endif

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]            req_off;
  logic                  req_bad_op;
  logic                  req_misalign;
  logic [4:0]            load_shift;
  logic [DATA_WIDTH-1:0] load_raw;
  logic [DATA_WIDTH-1:0] load_result;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = {24'd0, raw[7:0]};
      3'b101:  extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  assign req_off    = lsu.req_addr[1:0];
  assign req_bad_op = (lsu.req_funct3 == 3'b011) || (lsu.req_funct3[2:1] == 2'b11) ||
                      (lsu.req_we && lsu.req_funct3[2]);
  assign load_shift = {off_q, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_misalign = 1'b0;
  assign crossing     = (3'({1'b0, off_q}) + size_bytes(f3_q[1:0])) > 3'd4;
  // Split loads combine the first captured word (low) with the second word (high).
  assign load_raw     = (state == ACC1) ? 32'({lsu.mem_rdata, rdata0_q} >> load_shift)
                                        : lsu.mem_rdata >> load_shift;
`else
  assign req_misalign = (req_off & 2'(size_bytes(lsu.req_funct3[1:0]) - 3'd1)) != 2'b00;
  assign load_raw     = lsu.mem_rdata >> load_shift;
`endif

  assign load_result = we_q ? '0 : extend(f3_q, load_raw);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (lsu.req_valid) next_state = (req_bad_op || req_misalign) ? RESP : ACC0;
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC0: if (lsu.mem_ack) next_state = crossing ? ACC1 : RESP;
      ACC1: if (lsu.mem_ack) next_state = RESP;
`else
      ACC0: if (lsu.mem_ack) next_state = RESP;
`endif
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; memory fields hold while waiting for ack.
  always_comb begin
    req_ready_d = (next_state == IDLE);
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state)
      IDLE: begin
        if (lsu.req_valid) begin
          if (req_bad_op || req_misalign) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = lsu.req_we;
            mem_addr_d  = {lsu.req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = 4'(size_mask(lsu.req_funct3[1:0]) << req_off);
            mem_wdata_d = lsu.req_wdata << {req_off, 3'b000};
          end
        end
      end
      ACC0, ACC1: begin
        if (next_state == RESP) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_result;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (next_state == ACC1) begin
          mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
          mem_be_d    = size_mask(f3_q[1:0]) >> (3'd4 - {1'b0, off_q});
          mem_wdata_d = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      wdata_q     <= '0;
      rdata0_q    <= '0;
`endif
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (state == IDLE && lsu.req_valid) begin
        we_q    <= lsu.req_we;
        f3_q    <= lsu.req_funct3;
        off_q   <= req_off;
`ifdef LSU_MISALIGN_SPLIT_EN
        wdata_q <= lsu.req_wdata;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == ACC0 && lsu.mem_ack) rdata0_q <= lsu.mem_rdata;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign lsu.req_ready = req_ready_q;
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_err   = rsp_err_q;
  assign lsu.rsp_rdata = rsp_rdata_q;
  assign lsu.mem_req   = mem_req_q;
  assign lsu.mem_we    = mem_we_q;
  assign lsu.mem_addr  = mem_addr_q;
  assign lsu.mem_be    = mem_be_q;
  assign lsu.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed self-checking bench for lsu_align_unit; expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_align_unit;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_align_unit_if #(.ADDR_WIDTH(AW)) bus ();
  lsu_align_unit #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .lsu(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    step();
    bus.req_valid  = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd1);
    check({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_no_mem_req"}, 32'(bus.mem_req), 32'd0);
    step();
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_no_mem_req2"}, 32'(bus.mem_req), 32'd0);
  endtask

  task automatic expect_load_done(input string tag, input logic [31:0] data);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_rdata"}, bus.rsp_rdata, data);
    check({tag, "_mem_req_drop"}, 32'(bus.mem_req), 32'd0);
    step();
    check({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    step();
    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b0;
    step();

    // Stray ack in IDLE must be ignored
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
    check("idle_ack_req", 32'(bus.mem_req), 32'd0);

    // LB 0x103
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check("lb_mem_req", 32'(bus.mem_req), 32'd1);
    check("lb_addr", bus.mem_addr, 32'h0000_0100);
    check("lb_be", 32'(bus.mem_be), 32'b1000);
    check("lb_we", 32'(bus.mem_we), 32'd0);
    check("lb_ready_busy", 32'(bus.req_ready), 32'd0);
    ack(32'h80AA_BBCC);
    expect_load_done("lb", 32'hFFFF_FF80);

    // SH 0x202 with a wait cycle and req_valid held high while busy
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b011;
    check("sh_addr", bus.mem_addr, 32'h0000_0200);
    check("sh_be", 32'(bus.mem_be), 32'b1100);
    check("sh_wdata", bus.mem_wdata, 32'hABCD_0000);
    check("sh_we", 32'(bus.mem_we), 32'd1);
    step();
    check("sh_hold_req", 32'(bus.mem_req), 32'd1);
    check("sh_hold_be", 32'(bus.mem_be), 32'b1100);
    check("sh_hold_rsp", 32'(bus.rsp_valid), 32'd0);
    ack(32'hFFFF_FFFF);
    bus.req_valid = 1'b0;
    check("sh_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("sh_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("sh_rdata", bus.rsp_rdata, 32'h0);
    step();
    check("sh_ready", 32'(bus.req_ready), 32'd1);
    check("sh_no_extra_req", 32'(bus.mem_req), 32'd0);

    // LH 0x6: upper half 0x8001, sign-extended
    issue(1'b0, 3'b001, 32'h0000_0006, 32'h0);
    check("lh_be", 32'(bus.mem_be), 32'b1100);
    check("lh_addr", bus.mem_addr, 32'h0000_0004);
    ack(32'h8001_7FFF);
    expect_load_done("lh", 32'hFFFF_8001);

    // LBU 0x101: byte 0xBB, zero-extended
    issue(1'b0, 3'b100, 32'h0000_0101, 32'h0);
    check("lbu_be", 32'(bus.mem_be), 32'b0010);
    ack(32'h80AA_BBCC);
    expect_load_done("lbu", 32'h0000_00BB);

`ifdef LSU_MISALIGN_SPLIT_EN
    // LW 0x1 split into two words
    issue(1'b0, 3'b010, 32'h0000_0001, 32'h0);
    check("lw_split_addr0", bus.mem_addr, 32'h0000_0000);
    check("lw_split_be0", 32'(bus.mem_be), 32'b1110);
    ack(32'h4433_2211);
    check("lw_split_req1", 32'(bus.mem_req), 32'd1);
    check("lw_split_addr1", bus.mem_addr, 32'h0000_0004);
    check("lw_split_be1", 32'(bus.mem_be), 32'b0001);
    check("lw_split_no_rsp", 32'(bus.rsp_valid), 32'd0);
    ack(32'h8877_6655);
    expect_load_done("lw_split", 32'h5544_3322);

    // LH 0x1 stays within one word
    issue(1'b0, 3'b001, 32'h0000_0001, 32'h0);
    check("lh_off1_be", 32'(bus.mem_be), 32'b0110);
    ack(32'h4433_2211);
    expect_load_done("lh_off1", 32'h0000_3322);

    // SW 0xFFFFFFFE wraps to address 0
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
    check("sw_wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
    check("sw_wrap_be0", 32'(bus.mem_be), 32'b1100);
    check("sw_wrap_wdata0", bus.mem_wdata, 32'hBEEF_0000);
    ack(32'h0);
    check("sw_wrap_addr1", bus.mem_addr, 32'h0000_0000);
    check("sw_wrap_be1", 32'(bus.mem_be), 32'b0011);
    check("sw_wrap_wdata1", bus.mem_wdata, 32'h0000_DEAD);
    ack(32'h0);
    expect_load_done("sw_wrap", 32'h0);
`else
    issue(1'b0, 3'b010, 32'h0000_0001, 32'h0);
    expect_err("lw_misalign");
    issue(1'b0, 3'b001, 32'h0000_0001, 32'h0);
    expect_err("lh_off1");
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
    expect_err("sw_wrap");
`endif

    // Illegal encodings
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    expect_err("ld_f3_011");
    issue(1'b1, 3'b100, 32'h0000_0040, 32'h0);
    expect_err("st_f3_100");
    issue(1'b0, 3'b111, 32'h0000_0040, 32'h0);
    expect_err("ld_f3_111");

    // LHU 0x10 abandoned by reset while waiting for ack
    issue(1'b0, 3'b101, 32'h0000_0010, 32'h0);
    check("abort_req", 32'(bus.mem_req), 32'd1);
    check("abort_addr", bus.mem_addr, 32'h0000_0010);
    check("abort_be", 32'(bus.mem_be), 32'b0011);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check("abort_rsp_after", 32'(bus.rsp_valid), 32'd0);

    issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    check("lw_after_addr", bus.mem_addr, 32'h0000_0020);
    check("lw_after_be", 32'(bus.mem_be), 32'b1111);
    ack(32'hCAFE_F00D);
    expect_load_done("lw_after", 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
